// File: rtl/rv_pkg.sv
// rv_pkg: shared widths and the write-port arbiter grant encoding.
package rv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;
    typedef enum logic [1:0] {GNT_NONE, GNT_PIPE, GNT_HOLD, GNT_HOLD_FORCED} grant_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending mul/div destination tracking and issue gating.
// Ports: clk/rst; set_en/set_addr mark an accepted issue; clr_en/clr_addr retire
// a drained result; issue_addr -> issue_ready; rs1Addr/rs2Addr -> rs1_busy/rs2_busy.
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    input  logic [REG_ADDR_W-1:0] rs1Addr,
    input  logic [REG_ADDR_W-1:0] rs2Addr,
    output logic                  issue_ready,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_OUT);

    logic [NREG-1:0] busy;
    logic [CW-1:0]   out_cnt;
    logic            dec;

    // Bit 0 is never set, so x0 always reads as not busy.
    assign rs1_busy = busy[rs1Addr];
    assign rs2_busy = busy[rs2Addr];
    assign dec      = clr_en && out_cnt != '0;
    // A slot retiring this cycle frees room for an issue in the same cycle.
    assign issue_ready = !busy[issue_addr] && (out_cnt < CMAX || dec);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= '0;
            out_cnt <= '0;
        end else begin
            if (clr_en) busy[clr_addr] <= 1'b0;
            if (set_en && set_addr != '0) busy[set_addr] <= 1'b1;
            out_cnt <= (set_en && !dec) ? out_cnt + 1'b1 :
                       (!set_en && dec) ? out_cnt - 1'b1 : out_cnt;
        end
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the register-file write port between pipeline
// writeback and a one-entry mul/div result hold buffer.
// Ports: pipe_we/addr/data + pipe_stall (pipeline side); md_valid/addr/data +
// md_ready (mul/div results); issue_valid/addr + issue_ready (mul/div issue);
// rs1Addr/rs2Addr -> rs1_busy/rs2_busy (decode); RegWrite/WriteAddr/WriteData
// (registered write port).
module regfile_wb_scheduler
    import rv_pkg::*;
#(
    parameter int MAX_OUT      = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_addr,
    input  logic [XLEN-1:0]       pipe_data,
    output logic                  pipe_stall,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_addr,
    input  logic [XLEN-1:0]       md_data,
    output logic                  md_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] rs1Addr,
    input  logic [REG_ADDR_W-1:0] rs2Addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteAddr,
    output logic [XLEN-1:0]       WriteData
);
    localparam int AW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW-1:0] LIM = AW'(STARVE_LIMIT);

    logic                  hold_valid;
    logic [REG_ADDR_W-1:0] hold_addr;
    logic [XLEN-1:0]       hold_data;
    logic [AW-1:0]         age;
    grant_t                gnt;
    logic                  drain;
    logic                  pipe_win;

    // A starved hold result overrides the pipeline; otherwise the pipeline has priority.
    assign gnt = (hold_valid && age >= LIM)  ? GNT_HOLD_FORCED :
                 (pipe_we && pipe_addr != '0) ? GNT_PIPE :
                 hold_valid                   ? GNT_HOLD : GNT_NONE;
    assign pipe_win   = gnt == GNT_PIPE;
    assign drain      = gnt == GNT_HOLD || gnt == GNT_HOLD_FORCED;
    assign pipe_stall = gnt == GNT_HOLD_FORCED;
    assign md_ready   = !hold_valid || drain;

    regfile_scoreboard #(.MAX_OUT(MAX_OUT)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en     (issue_valid && issue_ready),
        .set_addr   (issue_addr),
        .clr_en     (drain),
        .clr_addr   (hold_addr),
        .issue_addr (issue_addr),
        .rs1Addr    (rs1Addr),
        .rs2Addr    (rs2Addr),
        .issue_ready(issue_ready),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite   <= 1'b0;
            WriteAddr  <= '0;
            WriteData  <= '0;
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
            age        <= '0;
        end else begin
            // A held result for x0 drains without touching the register file.
            RegWrite  <= pipe_win || (drain && hold_addr != '0);
            WriteAddr <= pipe_win ? pipe_addr : hold_addr;
            WriteData <= pipe_win ? pipe_data : hold_data;
            if (md_valid && md_ready) begin
                hold_valid <= 1'b1;
                hold_addr  <= md_addr;
                hold_data  <= md_data;
            end else if (drain) begin
                hold_valid <= 1'b0;
            end
            age <= (!hold_valid || drain) ? '0 : (age < LIM ? age + 1'b1 : age);
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: vector table plus write-port scoreboard for regfile_wb_scheduler.
module tb_regfile_wb_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we, md_valid, issue_valid;
    logic [4:0]  pipe_addr, md_addr, issue_addr, rs1Addr, rs2Addr;
    logic [31:0] pipe_data, md_data;
    logic        pipe_stall, md_ready, issue_ready, rs1_busy, rs2_busy, RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;

    regfile_wb_scheduler dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [4:0] a; logic [31:0] d; int c;} wr_t;
    typedef struct {logic we; logic [4:0] a; logic [31:0] d; logic stall;} pv_t;

    wr_t         q[$];
    pv_t         pv[6];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          outstanding = 0;
    logic [31:0] busy_m = '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic exp_wr(logic [4:0] a, logic [31:0] d, int dc);
        q.push_back(wr_t'{a, d, cyc + dc});
    endtask

    task automatic issue(logic [4:0] a, logic exp_rdy);
        issue_valid = 1'b1;
        issue_addr  = a;
        sample();
        chk("issue_ready", {31'b0, issue_ready}, {31'b0, exp_rdy});
        if (exp_rdy) begin
            outstanding++;
            if (a != 0) busy_m[a] = 1'b1;
        end
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic md_set(logic [4:0] a, logic [31:0] d);
        assert (outstanding > 0) else $error("mul/div result with no outstanding operation");
        md_valid = 1'b1;
        md_addr  = a;
        md_data  = d;
        outstanding--;
        busy_m[a] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d writes pending, required 0", q.size());
            q.delete();
        end
    endtask

    // Write-port monitor: every register-file write must match the next expected one.
    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            wr_t e;
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got x%0d=%h, required no write (cycle %0d)", WriteAddr, WriteData, cyc);
            end else begin
                e = q.pop_front();
                chk("wr_addr", {27'b0, WriteAddr}, {27'b0, e.a});
                chk("wr_data", WriteData, e.d);
                chk("wr_cycle", cyc, e.c);
            end
        end
    end

    // Decode stalling should keep the pipeline off registers awaiting mul/div results.
    always @(negedge clk) begin
        if (rst === 1'b0 && pipe_we === 1'b1 && pipe_addr != 0)
            assert (!busy_m[pipe_addr]) else $error("pipeline WAW on pending x%0d", pipe_addr);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        {pipe_we, md_valid, issue_valid} = '0;
        {pipe_addr, md_addr, issue_addr, rs1Addr, rs2Addr} = '0;
        pipe_data = '0;
        md_data   = '0;
        pv[0] = pv_t'{1'b1, 5'd5,  32'hDEADBEEF, 1'b0};
        pv[1] = pv_t'{1'b1, 5'd0,  32'h11111111, 1'b0};
        pv[2] = pv_t'{1'b0, 5'd9,  32'h22222222, 1'b0};
        pv[3] = pv_t'{1'b1, 5'd31, 32'hA5A5A5A5, 1'b0};
        pv[4] = pv_t'{1'b1, 5'd1,  32'h00000000, 1'b0};
        pv[5] = pv_t'{1'b1, 5'd0,  32'h0000FFFF, 1'b0};
        repeat (2) tick();
        sample();
        chk("rst_regwrite", {31'b0, RegWrite}, 0);
        chk("rst_waddr", {27'b0, WriteAddr}, 0);
        chk("rst_wdata", WriteData, 0);
        chk("rst_md_ready", {31'b0, md_ready}, 1);
        chk("rst_issue_ready", {31'b0, issue_ready}, 1);
        chk("rst_stall", {31'b0, pipe_stall}, 0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            pipe_we = pv[i].we; pipe_addr = pv[i].a; pipe_data = pv[i].d;
            sample();
            chk("pipe_stall", {31'b0, pipe_stall}, {31'b0, pv[i].stall});
            if (pv[i].we && pv[i].a != 0) exp_wr(pv[i].a, pv[i].d, 1);
            tick();
        end
        pipe_we = 1'b0;
        drain();

        rs1Addr = 5'd7; rs2Addr = 5'd7;
        issue(5'd7, 1'b1);
        issue(5'd7, 1'b0);
        sample();
        chk("rs1_busy_set", {31'b0, rs1_busy}, 1);
        chk("rs2_busy_set", {31'b0, rs2_busy}, 1);
        tick();
        md_set(5'd7, 32'h1234);
        sample();
        chk("md_ready_idle", {31'b0, md_ready}, 1);
        exp_wr(5'd7, 32'h1234, 2);
        tick();
        md_valid = 1'b0;
        sample();
        chk("rs1_busy_held", {31'b0, rs1_busy}, 1);
        tick();
        sample();
        chk("rs1_busy_clear", {31'b0, rs1_busy}, 0);
        drain();

        issue(5'd3, 1'b1);
        md_set(5'd3, 32'h33);
        pipe_we = 1'b1; pipe_addr = 5'd4; pipe_data = 32'h44;
        sample();
        chk("coll_md_ready", {31'b0, md_ready}, 1);
        chk("coll_stall0", {31'b0, pipe_stall}, 0);
        exp_wr(5'd4, 32'h44, 1);
        tick();
        md_valid = 1'b0;
        for (int a = 5; a < 8; a++) begin
            pipe_addr = 5'(a); pipe_data = 32'(a * 17);
            sample();
            chk("coll_pipe_wins", {31'b0, pipe_stall}, 0);
            exp_wr(5'(a), 32'(a * 17), 1);
            tick();
        end
        pipe_addr = 5'd8; pipe_data = 32'h88;
        sample();
        chk("coll_forced_stall", {31'b0, pipe_stall}, 1);
        exp_wr(5'd3, 32'h33, 1);
        tick();
        sample();
        chk("coll_stall_release", {31'b0, pipe_stall}, 0);
        exp_wr(5'd8, 32'h88, 1);
        tick();
        pipe_we = 1'b0;
        drain();

        issue(5'd10, 1'b1);
        issue(5'd11, 1'b1);
        md_set(5'd10, 32'hA0A0);
        pipe_we = 1'b1; pipe_addr = 5'd12; pipe_data = 32'h12;
        sample();
        exp_wr(5'd12, 32'h12, 1);
        tick();
        md_set(5'd11, 32'hB1B1);
        pipe_addr = 5'd13; pipe_data = 32'h13;
        sample();
        chk("bp_md_ready0", {31'b0, md_ready}, 0);
        exp_wr(5'd13, 32'h13, 1);
        tick();
        pipe_addr = 5'd14; pipe_data = 32'h14;
        sample();
        chk("bp_md_ready1", {31'b0, md_ready}, 0);
        exp_wr(5'd14, 32'h14, 1);
        tick();
        pipe_we = 1'b0;
        sample();
        chk("bp_md_ready_drain", {31'b0, md_ready}, 1);
        exp_wr(5'd10, 32'hA0A0, 1);
        exp_wr(5'd11, 32'hB1B1, 2);
        tick();
        md_valid = 1'b0;
        drain();

        for (int a = 1; a < 5; a++) issue(5'(a), 1'b1);
        issue(5'd5, 1'b0);
        md_set(5'd1, 32'hD1);
        issue_valid = 1'b1; issue_addr = 5'd5;
        sample();
        chk("cap_full", {31'b0, issue_ready}, 0);
        exp_wr(5'd1, 32'hD1, 2);
        tick();
        md_valid = 1'b0;
        sample();
        chk("cap_drain_accept", {31'b0, issue_ready}, 1);
        outstanding++; busy_m[5] = 1'b1;
        tick();
        issue_addr = 5'd6;
        sample();
        chk("cap_still_full", {31'b0, issue_ready}, 0);
        tick();
        issue_valid = 1'b0;

        md_set(5'd2, 32'hD2);
        sample();
        exp_wr(5'd2, 32'hD2, 2);
        tick();
        md_valid = 1'b0;
        issue_valid = 1'b1; issue_addr = 5'd9;
        sample();
        chk("rst_pre_issue", {31'b0, issue_ready}, 1);
        outstanding++; busy_m[9] = 1'b1;
        tick();
        issue_valid = 1'b0;
        md_set(5'd3, 32'hD3);
        pipe_we = 1'b1; pipe_addr = 5'd20; pipe_data = 32'h20;
        sample();
        chk("rst_pre_capture", {31'b0, md_ready}, 1);
        exp_wr(5'd20, 32'h20, 1);
        tick();
        md_valid = 1'b0; pipe_we = 1'b0;
        rst = 1'b1; rs1Addr = 5'd9;
        sample();
        chk("rst_pre_busy9", {31'b0, rs1_busy}, 1);
        tick();
        rst = 1'b0; outstanding = 0; busy_m = '0;
        sample();
        chk("mid_rst_regwrite", {31'b0, RegWrite}, 0);
        chk("mid_rst_busy9", {31'b0, rs1_busy}, 0);
        chk("mid_rst_md_ready", {31'b0, md_ready}, 1);
        chk("mid_rst_issue_ready", {31'b0, issue_ready}, 1);
        tick();

        for (int i = 0; i < 4; i++) issue(5'd0, 1'b1);
        issue(5'd0, 1'b0);
        md_set(5'd0, 32'hFFFF);
        sample();
        tick();
        md_valid = 1'b0;
        tick();
        issue_addr = 5'd0;
        sample();
        chk("x0_drain_frees_slot", {31'b0, issue_ready}, 1);
        tick();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
